// File: rtl/dbg_pkg.sv
// Shared definitions for the register-dump debug transmitter: framing constants, the dump
// word-index to register-address table and the transmitter state type.
package dbg_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned DUMP_WORDS = 14;
  localparam logic [3:0]  LAST_IDX   = 4'(DUMP_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } dbg_state_e;

  // Words 2..9 carry $s0-$s7 (regs 16..23), words 10..13 carry $t0-$t3 (regs 8..11).
  function automatic logic [4:0] dbg_reg_addr(input logic [3:0] idx);
    logic [4:0] addr;
    addr = 5'd0;
    if (idx >= 4'd2 && idx <= 4'd9) begin
      addr = 5'(idx) + 5'd14;
    end else if (idx >= 4'd10 && idx <= 4'd13) begin
      addr = 5'(idx) - 5'd2;
    end
    return addr;
  endfunction

endpackage

// File: rtl/reg_dump_tx.sv
// Streams a header, the latched PC and twelve monitored registers over valid/ready while
// holding the core so the register file stays coherent for the whole dump.
module reg_dump_tx
  import dbg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [DATA_W-1:0] pc,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cpu_hold,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [3:0]        dump_idx,
  output logic              dump_last,
  output logic              overrun
);

  dbg_state_e        r_state;
  dbg_state_e        w_state_next;
  logic [3:0]        r_idx;
  logic [SEQ_W-1:0]  r_seq;
  logic [DATA_W-1:0] r_pc;
  logic              r_overrun;
  logic              w_accept;
  logic              w_done;
  logic [DATA_W-1:0] w_header;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (trigger) begin
          w_accept     = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (dump_ready && r_idx == LAST_IDX) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= 4'd0;
      r_seq     <= '0;
      r_pc      <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pc  <= pc;
        r_idx <= 4'd0;
      end else if (r_state == SEND && dump_ready) begin
        r_idx <= w_done ? 4'd0 : r_idx + 4'd1;
      end
      if (w_done) begin
        r_seq <= r_seq + 1'b1;
      end
      // Any trigger seen while busy, even on the closing handshake, is lost and flagged.
      if (r_state == SEND && trigger) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign w_header   = DATA_W'({r_seq, 8'(DUMP_WORDS), SYNC_BYTE});
  assign dump_valid = (r_state == SEND);
  assign cpu_hold   = (r_state == SEND);
  assign dump_idx   = r_idx;
  assign dump_last  = dump_valid && (r_idx == LAST_IDX);
  assign overrun    = r_overrun;
  assign rd_addr    = (dump_valid && r_idx >= 4'd2) ? ADDR_W'(dbg_reg_addr(r_idx)) : '0;

  always_comb begin
    dump_data = '0;
    if (dump_valid) begin
      unique case (r_idx)
        4'd0:    dump_data = w_header;
        4'd1:    dump_data = r_pc;
        default: dump_data = rd_data;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Randomized bench for reg_dump_tx against a word-list model of the dump frame.
module tb_reg_dump_tx;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic [31:0] pc;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        cpu_hold;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [3:0]  dump_idx;
  logic        dump_last;
  logic        overrun;

  logic [31:0] regs [32];
  int          regmap [14] = '{0, 0, 16, 17, 18, 19, 20, 21, 22, 23, 8, 9, 10, 11};
  int          exp_seq;
  int          n_total;
  int          n_bad;

  reg_dump_tx #(
    .DATA_W(32),
    .ADDR_W(5),
    .SEQ_W (16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger   (trigger),
    .pc        (pc),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cpu_hold  (cpu_hold),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_data (dump_data),
    .dump_idx  (dump_idx),
    .dump_last (dump_last),
    .overrun   (overrun)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(dump_valid), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_data"}, dump_data, 32'd0);
    chk({tag, "_last"}, 32'(dump_last), 32'd0);
    chk({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
  endtask

  // mode: 0 ready held high, 1 ready toggles 1/0, 2 random ready.
  task automatic do_dump(input logic [31:0] pc_v, input int mode, input bit trig5,
                         input bit trig_last, input int abort_at, input int exp_cyc);
    int          k;
    int          cyc;
    bit          fired5;
    logic [31:0] expw;
    @(negedge clk);
    pc      = pc_v;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    pc      = $urandom();
    k       = 0;
    cyc     = 0;
    fired5  = 1'b0;
    while (k < 14 && cyc < 200) begin
      if (k == 0)      expw = {exp_seq[15:0], 8'd14, 8'hA5};
      else if (k == 1) expw = pc_v;
      else             expw = regs[regmap[k]];
      chk("valid", 32'(dump_valid), 32'd1);
      chk("hold", 32'(cpu_hold), 32'd1);
      chk("idx", 32'(dump_idx), 32'(k));
      chk("data", dump_data, expw);
      chk("last", 32'(dump_last), 32'(k == 13));
      chk("rd_addr", 32'(rd_addr), (k < 2) ? 32'd0 : 32'(regmap[k]));
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        chk("abort_overrun", 32'(overrun), 32'd0);
        chk("abort_idx", 32'(dump_idx), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        dump_ready = 1'b1;
        exp_seq    = 0;
        return;
      end
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc % 2 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      trigger = 1'b0;
      if (trig5 && k == 5 && !fired5) begin
        trigger = 1'b1;
        fired5  = 1'b1;
      end
      if (trig_last && k == 13 && dump_ready) trigger = 1'b1;
      if (dump_ready) k++;
      cyc++;
      @(negedge clk);
    end
    trigger = 1'b0;
    if (cyc >= 200) chk("timeout", 32'(k), 32'd14);
    if (exp_cyc >= 0) chk("cycles", 32'(cyc), 32'(exp_cyc));
    exp_seq = (exp_seq + 1) % 65536;
    chk_idle_outputs("end");
    if (trig5 || trig_last) chk("overrun_set", 32'(overrun), 32'd1);
    @(negedge clk);
    chk("no_redump", 32'(dump_valid), 32'd0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    exp_seq    = 0;
    rst_n      = 1'b0;
    trigger    = 1'b0;
    pc         = 32'd0;
    dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    #1;
    chk_idle_outputs("reset");
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_idx", 32'(dump_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle");

    do_dump(32'h0040_0010, 0, 1'b0, 1'b0, -1, 14);
    chk("overrun_quiet", 32'(overrun), 32'd0);
    do_dump($urandom(), 1, 1'b0, 1'b0, -1, 27);
    do_dump($urandom(), 2, 1'b0, 1'b0, -1, -1);

    regs[16] = 32'hDEAD_BEEF;
    regs[11] = 32'h1234_5678;
    do_dump($urandom(), 0, 1'b0, 1'b0, -1, 14);
    chk("overrun_still_clear", 32'(overrun), 32'd0);

    do_dump($urandom(), 0, 1'b1, 1'b1, -1, 14);
    do_dump($urandom(), 2, 1'b0, 1'b0, -1, -1);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    do_dump($urandom(), 0, 1'b0, 1'b0, 6, -1);
    @(negedge clk);
    chk_idle_outputs("post_abort");
    do_dump(32'h0040_0100, 0, 1'b0, 1'b0, -1, 14);
    chk("post_abort_overrun", 32'(overrun), 32'd0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      do_dump($urandom(), 2, 1'(n[0]), 1'b0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
